sar_ctrl_seq: RTL and testbench



---
 rtl/sar_ctrl_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_sar_ctrl_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sar_ctrl_seq.sv
// sar_ctrl_seq: multi-channel SAR ADC sequencer with per-channel accumulation.
//
// Scans NCH input channels per start. For each channel it runs 2^NAVG_LOG2
// successive-approximation conversions and returns their sum on DOUT, tagged
// with DCH. Each conversion is a sample phase of NSAMP cycles, then NBITS
// trial cycles, then one DONE cycle. Conversions run back to back.
//
// Build option (macro SAR_CONT_EN):
//   undefined - a scan starts on a GO rising edge seen in IDLE; scan end -> IDLE.
//   defined   - a scan starts while GO is high in IDLE; if GO is still high in
//               the final DONE cycle, the next scan starts with no IDLE cycle.
//
// Ports:
//   CLK     clock
//   RST     synchronous reset, active high
//   GO      start request, sampled in IDLE only
//   CMP     comparator decision, 1 = keep the bit under trial
//   SAMPLE  high during the sample phase
//   RESULTP P-side CDAC code (trial code during CONV, final code in DONE)
//   RESULTN N-side CDAC code, always the inverse of RESULTP
//   CHSEL   input-mux channel being sampled/converted
//   BUSY    high whenever the sequencer is not IDLE
//   VALID   one-cycle strobe qualifying DOUT/DCH
//   DOUT    accumulated sum of the channel's conversions
//   DCH     channel index of DOUT
// All outputs come straight from flops.

module sar_ctrl_seq #(
  parameter int unsigned NBITS     = 5,
  parameter int unsigned NCH       = 4,
  parameter int unsigned CHW       = 2,
  parameter int unsigned NAVG_LOG2 = 0,
  parameter int unsigned NSAMP     = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       GO,
  input  logic                       CMP,
  output logic                       SAMPLE,
  output logic [NBITS-1:0]           RESULTP,
  output logic [NBITS-1:0]           RESULTN,
  output logic [CHW-1:0]             CHSEL,
  output logic                       BUSY,
  output logic                       VALID,
  output logic [NBITS+NAVG_LOG2-1:0] DOUT,
  output logic [CHW-1:0]             DCH
);

  localparam int unsigned AccW  = NBITS + NAVG_LOG2;
  localparam int unsigned AvgW  = (NAVG_LOG2 > 0) ? NAVG_LOG2 : 1;
  localparam int unsigned BitW  = $clog2(NBITS);
  localparam int unsigned SampW = (NSAMP > 1) ? $clog2(NSAMP) : 1;

  localparam logic [AvgW-1:0]  AvgLast  = AvgW'((1 << NAVG_LOG2) - 1);
  localparam logic [SampW-1:0] SampLast = SampW'(NSAMP - 1);
  localparam logic [CHW-1:0]   ChLast   = CHW'(NCH - 1);
  localparam logic [BitW-1:0]  BitTop   = BitW'(NBITS - 1);
  localparam logic [NBITS-1:0] MsbCode  = {1'b1, {(NBITS-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StSamp,
    StConv,
    StDone
  } state_e;

  state_e            state_q;
  logic [SampW-1:0]  samp_cnt_q;
  logic [BitW-1:0]   bit_q;
  logic [AvgW-1:0]   avg_cnt_q;
  logic [AccW-1:0]   acc_q;
  logic              sample_q;
  logic [NBITS-1:0]  resultp_q;
  logic [NBITS-1:0]  resultn_q;
  logic [CHW-1:0]    chsel_q;
  logic              busy_q;
  logic              valid_q;
  logic [AccW-1:0]   dout_q;
  logic [CHW-1:0]    dch_q;

  logic [NBITS-1:0]  code_nxt;
  logic [AccW-1:0]   acc_sum;
  logic              avg_last;
  logic              ch_last;
  logic              start;

`ifdef SAR_CONT_EN
  assign start = GO;
`else
  logic go_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      go_q <= 1'b0;
    end else begin
      go_q <= GO;
    end
  end

  // Rising edge only, so a GO held high produces a single scan.
  assign start = GO & ~go_q;
`endif

  // Trial-bit resolution: drop the bit under test on CMP=0, then place the
  // next trial bit below it. Bits above bit_q are already final.
  always_comb begin
    code_nxt = resultp_q;
    if (!CMP) begin
      code_nxt[bit_q] = 1'b0;
    end
    if (bit_q != '0) begin
      code_nxt[bit_q - 1'b1] = 1'b1;
    end
  end

  // Sum including the conversion that is finishing this cycle. Width holds
  // 2^NAVG_LOG2 full-scale codes, so it never wraps.
  assign acc_sum  = acc_q + AccW'(code_nxt);
  assign avg_last = (avg_cnt_q == AvgLast);
  assign ch_last  = (chsel_q == ChLast);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      samp_cnt_q <= '0;
      bit_q      <= '0;
      avg_cnt_q  <= '0;
      acc_q      <= '0;
      sample_q   <= 1'b0;
      resultp_q  <= '0;
      resultn_q  <= '1;
      chsel_q    <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      dout_q     <= '0;
      dch_q      <= '0;
    end else begin
      valid_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StSamp;
            sample_q   <= 1'b1;
            busy_q     <= 1'b1;
            samp_cnt_q <= '0;
            chsel_q    <= '0;
            avg_cnt_q  <= '0;
            acc_q      <= '0;
            resultp_q  <= '0;
            resultn_q  <= '1;
          end
        end

        StSamp: begin
          if (samp_cnt_q == SampLast) begin
            state_q   <= StConv;
            sample_q  <= 1'b0;
            bit_q     <= BitTop;
            resultp_q <= MsbCode;
            resultn_q <= ~MsbCode;
          end else begin
            samp_cnt_q <= samp_cnt_q + 1'b1;
          end
        end

        StConv: begin
          resultp_q <= code_nxt;
          resultn_q <= ~code_nxt;
          if (bit_q == '0) begin
            // VALID/DOUT are loaded here so they are visible during DONE.
            state_q <= StDone;
            if (avg_last) begin
              valid_q   <= 1'b1;
              dout_q    <= acc_sum;
              dch_q     <= chsel_q;
              acc_q     <= '0;
              avg_cnt_q <= '0;
            end else begin
              acc_q     <= acc_sum;
              avg_cnt_q <= avg_cnt_q + 1'b1;
            end
          end else begin
            bit_q <= bit_q - 1'b1;
          end
        end

        StDone: begin
          // valid_q high here marks the last conversion of this channel.
          if (valid_q) begin
            chsel_q <= ch_last ? '0 : chsel_q + 1'b1;
          end
          if (valid_q && ch_last) begin
`ifdef SAR_CONT_EN
            if (GO) begin
              state_q    <= StSamp;
              sample_q   <= 1'b1;
              samp_cnt_q <= '0;
            end else begin
              state_q    <= StIdle;
              busy_q     <= 1'b0;
            end
`else
            state_q <= StIdle;
            busy_q  <= 1'b0;
`endif
          end else begin
            state_q    <= StSamp;
            sample_q   <= 1'b1;
            samp_cnt_q <= '0;
          end
          resultp_q <= '0;
          resultn_q <= '1;
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign SAMPLE  = sample_q;
  assign RESULTP = resultp_q;
  assign RESULTN = resultn_q;
  assign CHSEL   = chsel_q;
  assign BUSY    = busy_q;
  assign VALID   = valid_q;
  assign DOUT    = dout_q;
  assign DCH     = dch_q;

endmodule

// File: tb/tb_sar_ctrl_seq.sv
// Directed bench for sar_ctrl_seq: a default instance (no averaging) and an
// averaging instance (NAVG_LOG2=2), each driven by an ideal comparator that
// keeps a trial bit when the channel's input code is >= the trial code.

module tb_sar_ctrl_seq;

  logic       clk;
  logic       rst;

  // Default instance: NBITS=5, NCH=4, NAVG_LOG2=0, NSAMP=2.
  logic       go;
  logic       cmp;
  logic       sample;
  logic [4:0] resultp;
  logic [4:0] resultn;
  logic [1:0] chsel;
  logic       busy;
  logic       valid;
  logic [4:0] dout;
  logic [1:0] dch;
  logic [4:0] vin [4];

  // Averaging instance: NAVG_LOG2=2.
  logic       go_a;
  logic       cmp_a;
  logic       sample_a;
  logic [4:0] resultp_a;
  logic [4:0] resultn_a;
  logic [1:0] chsel_a;
  logic       busy_a;
  logic       valid_a;
  logic [6:0] dout_a;
  logic [1:0] dch_a;
  logic [4:0] vin_a;

  int n_checks = 0;
  int n_errors = 0;

  sar_ctrl_seq #(
    .NBITS(5), .NCH(4), .CHW(2), .NAVG_LOG2(0), .NSAMP(2)
  ) dut (
    .CLK(clk), .RST(rst), .GO(go), .CMP(cmp),
    .SAMPLE(sample), .RESULTP(resultp), .RESULTN(resultn), .CHSEL(chsel),
    .BUSY(busy), .VALID(valid), .DOUT(dout), .DCH(dch)
  );

  sar_ctrl_seq #(
    .NBITS(5), .NCH(4), .CHW(2), .NAVG_LOG2(2), .NSAMP(2)
  ) dut_avg (
    .CLK(clk), .RST(rst), .GO(go_a), .CMP(cmp_a),
    .SAMPLE(sample_a), .RESULTP(resultp_a), .RESULTN(resultn_a), .CHSEL(chsel_a),
    .BUSY(busy_a), .VALID(valid_a), .DOUT(dout_a), .DCH(dch_a)
  );

  assign cmp   = (vin[chsel] >= resultp);
  assign cmp_a = (vin_a >= resultp_a);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One GO pulse at cycle 0, then follow the scan to the first IDLE cycle (33).
  task automatic run_scan(input int v0, input int v1, input int v2, input int v3,
                          input bit trials);
    int exp_dout [4];
    int exp_trial [5];
    exp_dout  = '{v0, v1, v2, v3};
    exp_trial = '{16, 24, 20, 18, 19};
    vin[0] = 5'(v0);
    vin[1] = 5'(v1);
    vin[2] = 5'(v2);
    vin[3] = 5'(v3);
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      if (c % 8 == 0) begin
        check("valid_on", 32'(valid), 1);
        check("dch", 32'(dch), 32'(c / 8 - 1));
        check("dout", 32'(dout), 32'(exp_dout[c / 8 - 1]));
      end else begin
        check("valid_off", 32'(valid), 0);
      end
      if (trials) begin
        if (c == 1 || c == 2) check("sample_hi", 32'(sample), 1);
        if (c == 3) check("sample_lo", 32'(sample), 0);
        if (c >= 3 && c <= 7) check("trial", 32'(resultp), 32'(exp_trial[c - 3]));
        if (c == 8) check("resultn_final", 32'(resultn), 32'd12);
        if (c == 8) check("chsel_ch0", 32'(chsel), 0);
      end
      if (c == 32) check("busy_done", 32'(busy), 1);
      if (c == 33) check("busy_idle", 32'(busy), 0);
      if (c < 33) tick();
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 80) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 0);
  endtask

  initial begin
    int avg_tab [16];
    int avg_exp [4];
    avg_tab = '{7, 8, 8, 9, 31, 31, 31, 31, 0, 0, 0, 0, 5, 6, 7, 8};
    avg_exp = '{32, 124, 0, 26};

    rst   = 1'b1;
    go    = 1'b0;
    go_a  = 1'b0;
    vin_a = '0;
    for (int i = 0; i < 4; i++) vin[i] = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset values.
    check("rst_resultp", 32'(resultp), 0);
    check("rst_resultn", 32'(resultn), 31);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_sample", 32'(sample), 0);
    check("rst_chsel", 32'(chsel), 0);
    check("rst_dout", 32'(dout), 0);
    tick();

    // Single conversion trial sequence on ch0, then a full scan.
    run_scan(19, 31, 10, 21, 1'b1);
    tick();
    run_scan(0, 31, 10, 21, 1'b0);
    tick();

    // Averaging: four conversions per channel, VALID every 32 cycles.
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    for (int c = 1; c <= 129; c++) begin
      if ((c - 1) / 8 < 16) vin_a = 5'(avg_tab[(c - 1) / 8]);
      if (c == 1) check("avg_sample", 32'(sample_a), 1);
      if (c % 32 == 0) begin
        check("avg_valid_on", 32'(valid_a), 1);
        check("avg_dch", 32'(dch_a), 32'(c / 32 - 1));
        check("avg_dout", 32'(dout_a), 32'(avg_exp[c / 32 - 1]));
      end else begin
        check("avg_valid_off", 32'(valid_a), 0);
      end
      if (c == 129) begin
        check("avg_busy_idle", 32'(busy_a), 0);
        check("avg_chsel_wrap", 32'(chsel_a), 0);
        check("avg_resultn_idle", 32'(resultn_a), 31);
      end
      if (c < 129) tick();
    end

    // Reset during the third CONV cycle (cycle 5).
    vin[0] = 5'd0;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    check("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_valid", 32'(valid), 0);
    check("abort_resultp", 32'(resultp), 0);
    check("abort_sample", 32'(sample), 0);
    check("abort_resultn", 32'(resultn), 31);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("abort_quiet", 32'(valid) | 32'(busy), 0);
    end
    run_scan(0, 31, 10, 21, 1'b0);
    tick();

    // GO held high across the scan end.
    vin[0] = 5'd3;
    go = 1'b1;
    for (int c = 0; c < 32; c++) tick();
    check("hold_valid_last", 32'(valid), 1);
    check("hold_dch_last", 32'(dch), 3);
    tick();
`ifdef SAR_CONT_EN
    check("cont_sample", 32'(sample), 1);
    check("cont_busy", 32'(busy), 1);
    check("cont_chsel", 32'(chsel), 0);
    go = 1'b0;
    wait_idle("cont_end");
`else
    check("single_busy", 32'(busy), 0);
    check("single_sample", 32'(sample), 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("single_no_restart", 32'(busy), 0);
    end
    go = 1'b0;
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    check("rearm_sample", 32'(sample), 1);
    check("rearm_chsel", 32'(chsel), 0);
    wait_idle("rearm_end");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
